// File: rtl/coord_cursor_pkg.sv
// Shared types and helpers for the coordinate cursor writer.
//   state_t   : write-sequencer states
//   H_RES_DEF : default visible width
//   V_RES_DEF : default visible height
//   pix_addr  : byte address of a pixel in the XY-addressed pixel buffer
package coord_cursor_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      ERASE  = 2'd2,
      DRAW   = 2'd3
   } state_t;

   localparam int unsigned H_RES_DEF = 640;
   localparam int unsigned V_RES_DEF = 480;

   // XY addressing: 2 bytes per pixel, 2048-byte row stride.
   function automatic logic [31:0] pix_addr(input logic [31:0] base,
                                            input logic [9:0]  x,
                                            input logic [8:0]  y);
      return base + {12'd0, y, x, 1'b0};
   endfunction

endpackage

// File: rtl/cursor_square_walker.sv
// N x N pixel walker, row-major (dx fastest). Reused by the erase and
// draw phases of coord_cursor_writer.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous return to (0,0)
//   step         : advance to the next pixel (wraps after the last one)
//   dx, dy       : current offset within the square
//   last         : current offset is the final pixel (N-1, N-1)
module cursor_square_walker
   import coord_cursor_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       step,
   output logic [3:0] dx,
   output logic [3:0] dy,
   output logic       last
);

   localparam logic [3:0] MAX = 4'(N - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dx <= '0;
         dy <= '0;
      end else if (clear) begin
         dx <= '0;
         dy <= '0;
      end else if (step) begin
         if (dx == MAX) begin
            dx <= '0;
            dy <= (dy == MAX) ? 4'd0 : dy + 4'd1;
         end else begin
            dx <= dx + 4'd1;
         end
      end
   end

   assign last = (dx == MAX) && (dy == MAX);

endmodule

// File: rtl/coord_cursor_writer.sv
// Draws a solid NxN cursor into a 640x480 RGB565 pixel buffer over an
// Avalon-MM write master, driven by HPS-written x/y coordinate PIOs.
// Each settled coordinate change erases the previous square (if any) and
// then draws the new one.
// Ports:
//   clk, reset_n        : clock, async active-low reset
//   enable              : accept new coordinates (looked at in IDLE only)
//   x_coord, y_coord    : raw HPS coordinates
//   colour, bg_colour   : cursor and erase colours (RGB565)
//   m_address, m_write, m_writedata, m_byteenable, m_waitrequest : Avalon-MM master
//   busy                : sequencer is settling, erasing or drawing
//   clamped             : last drawn coordinate was pulled inside the screen
//   hex_value           : seven-segment value
// Build option CURSOR_HEX_EN: hex_value shows {x[7:0], y[7:0]} of the last
// drawn position; otherwise it is tied to zero.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an enabled coordinate that differs from last_raw
// SETTLE | counting consecutive equal samples up to STABLE_CYCLES
// ERASE  | writing bg_colour over the previous square
// DRAW   | writing colour over the new square
module coord_cursor_writer
   import coord_cursor_pkg::*;
#(
   parameter int unsigned H_RES         = H_RES_DEF,
   parameter int unsigned V_RES         = V_RES_DEF,
   parameter int unsigned CURSOR_SIZE   = 4,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter logic [31:0] BUF_BASE      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [31:0] x_coord,
   input  logic [31:0] y_coord,
   input  logic [15:0] colour,
   input  logic [15:0] bg_colour,
   output logic [31:0] m_address,
   output logic        m_write,
   output logic [15:0] m_writedata,
   output logic [1:0]  m_byteenable,
   input  logic        m_waitrequest,
   output logic        busy,
   output logic        clamped,
   output logic [15:0] hex_value
);

   localparam logic [31:0] X_MAX = 32'(H_RES - CURSOR_SIZE);
   localparam logic [31:0] Y_MAX = 32'(V_RES - CURSOR_SIZE);
   localparam logic [7:0]  STABLE_CNT = 8'(STABLE_CYCLES);

   state_t state, state_nxt;

   logic [31:0] samp_x, samp_y;
   logic [63:0] samp_raw, last_raw, settle_raw;
   logic [7:0]  cnt;
   logic        has_prev;
   logic [9:0]  prev_x, tgt_x, x_lim, cur_x, px;
   logic [8:0]  prev_y, tgt_y, y_lim, cur_y, py;
   logic        tgt_clamped, x_over, y_over;
   logic [15:0] pix_data;

   logic [3:0]  dx, dy;
   logic        walk_last;

   logic start_settle, inc_cnt, latch_tgt, walk_clear, walk_step;
   logic erase_done, finish;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_x <= '0;
         samp_y <= '0;
      end else begin
         samp_x <= x_coord;
         samp_y <= y_coord;
      end
   end

   assign samp_raw = {samp_x, samp_y};

   assign x_over = samp_x > X_MAX;
   assign y_over = samp_y > Y_MAX;
   assign x_lim  = x_over ? X_MAX[9:0] : samp_x[9:0];
   assign y_lim  = y_over ? Y_MAX[8:0] : samp_y[8:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      start_settle = 1'b0;
      inc_cnt      = 1'b0;
      latch_tgt    = 1'b0;
      walk_clear   = 1'b0;
      walk_step    = 1'b0;
      erase_done   = 1'b0;
      finish       = 1'b0;
      case (state)
         IDLE: begin
            if (enable && (samp_raw != last_raw)) begin
               start_settle = 1'b1;
               state_nxt    = SETTLE;
            end
         end
         SETTLE: begin
            if (samp_raw != settle_raw) begin
               start_settle = 1'b1;
            end else if (cnt == STABLE_CNT) begin
               latch_tgt  = 1'b1;
               walk_clear = 1'b1;
               state_nxt  = has_prev ? ERASE : DRAW;
            end else begin
               inc_cnt = 1'b1;
            end
         end
         ERASE: begin
            if (!m_waitrequest) begin
               if (walk_last) begin
                  // Straight into DRAW so m_write has no bubble between phases.
                  erase_done = 1'b1;
                  walk_clear = 1'b1;
                  state_nxt  = DRAW;
               end else begin
                  walk_step = 1'b1;
               end
            end
         end
         DRAW: begin
            if (!m_waitrequest) begin
               if (walk_last) begin
                  finish    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  walk_step = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // settle_raw is only rewritten in IDLE/SETTLE, so at the end of DRAW it
   // still holds the raw value that was drawn.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         settle_raw  <= '0;
         cnt         <= '0;
         last_raw    <= '0;
         has_prev    <= 1'b0;
         prev_x      <= '0;
         prev_y      <= '0;
         tgt_x       <= '0;
         tgt_y       <= '0;
         tgt_clamped <= 1'b0;
         clamped     <= 1'b0;
         pix_data    <= '0;
      end else begin
         if (start_settle) begin
            settle_raw <= samp_raw;
            cnt        <= 8'd1;
         end else if (inc_cnt) begin
            cnt <= cnt + 8'd1;
         end
         if (latch_tgt) begin
            tgt_x       <= x_lim;
            tgt_y       <= y_lim;
            tgt_clamped <= x_over || y_over;
            pix_data    <= has_prev ? bg_colour : colour;
         end
         if (erase_done) pix_data <= colour;
         if (finish) begin
            last_raw <= settle_raw;
            has_prev <= 1'b1;
            prev_x   <= tgt_x;
            prev_y   <= tgt_y;
            clamped  <= tgt_clamped;
         end
      end
   end

   cursor_square_walker #(
      .N (CURSOR_SIZE)
   ) u_walker (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (walk_clear),
      .step    (walk_step),
      .dx      (dx),
      .dy      (dy),
      .last    (walk_last)
   );

   // Master outputs come straight from registered state, so they cannot
   // move while m_waitrequest holds the walker, and m_write falls with reset.
   assign cur_x = (state == ERASE) ? prev_x : tgt_x;
   assign cur_y = (state == ERASE) ? prev_y : tgt_y;
   assign px    = cur_x + 10'(dx);
   assign py    = cur_y + 9'(dy);

   assign m_write      = (state == ERASE) || (state == DRAW);
   assign m_address    = m_write ? pix_addr(BUF_BASE, px, py) : 32'd0;
   assign m_writedata  = m_write ? pix_data : 16'd0;
   assign m_byteenable = m_write ? 2'b11 : 2'b00;
   assign busy         = (state != IDLE);

`ifdef CURSOR_HEX_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    hex_value <= '0;
      else if (finish) hex_value <= {tgt_x[7:0], tgt_y[7:0]};
   end
`else
   assign hex_value = 16'h0000;
`endif

endmodule

// File: tb/tb_coord_cursor_writer.sv
module tb_coord_cursor_writer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [31:0] x_coord, y_coord;
   logic [15:0] colour, bg_colour;
   logic [31:0] m_address;
   logic        m_write;
   logic [15:0] m_writedata;
   logic [1:0]  m_byteenable;
   logic        m_waitrequest;
   logic        busy, clamped;
   logic [15:0] hex_value;

   always #5 clk = ~clk;

   coord_cursor_writer dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .x_coord       (x_coord),
      .y_coord       (y_coord),
      .colour        (colour),
      .bg_colour     (bg_colour),
      .m_address     (m_address),
      .m_write       (m_write),
      .m_writedata   (m_writedata),
      .m_byteenable  (m_byteenable),
      .m_waitrequest (m_waitrequest),
      .busy          (busy),
      .clamped       (clamped),
      .hex_value     (hex_value)
   );

   localparam logic [15:0] COL = 16'hF800;
   localparam logic [15:0] BG  = 16'h001F;

   typedef struct packed {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;

   int          errors = 0;
   int          checks = 0;
   wr_t         exp_q[$];
   wr_t         e;
   logic [31:0] log_addr [0:1023];
   int          wr_total = 0;
   logic        in_stall = 1'b0;
   logic [31:0] stall_addr;
   logic [15:0] stall_data;
   int          base;
   int          k;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // 2 bytes per pixel, 2048 bytes per row, base 0
   function automatic logic [31:0] model_addr(input int x, input int y);
      return 32'(y * 2048 + x * 2);
   endfunction

   task automatic push_square(input int x, input int y, input logic [15:0] d);
      wr_t w;
      for (int yy = 0; yy < 4; yy++)
         for (int xx = 0; xx < 4; xx++) begin
            w.addr = model_addr(x + xx, y + yy);
            w.data = d;
            exp_q.push_back(w);
         end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!busy && n < 40) begin cyc(1); n++; end
      check({name, "_busy_rise"}, busy, 1);
      n = 0;
      while (busy && n < 600) begin cyc(1); n++; end
      check({name, "_busy_fall"}, busy, 0);
      cyc(1);
      check({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_writes(input string name, input int target);
      int n;
      n = 0;
      while (wr_total < target && n < 400) begin cyc(1); n++; end
      check({name, "_reached"}, wr_total >= target, 1);
   endtask

   // Monitor: a write completes at the next posedge when m_write && !m_waitrequest.
   always @(negedge clk) begin
      if (reset_n && m_write) begin
         if (m_waitrequest) begin
            if (!in_stall) begin
               in_stall   = 1'b1;
               stall_addr = m_address;
               stall_data = m_writedata;
            end else begin
               check("stall_addr", m_address, stall_addr);
               check("stall_data", m_writedata, stall_data);
            end
         end else begin
            in_stall = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                        m_address, m_writedata);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", m_address, e.addr);
               check("wr_data", m_writedata, e.data);
               check("wr_byteenable", m_byteenable, 2'b11);
            end
            if (wr_total < 1024) log_addr[wr_total] = m_address;
            wr_total++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n       = 1'b0;
      enable        = 1'b0;
      x_coord       = '0;
      y_coord       = '0;
      colour        = COL;
      bg_colour     = BG;
      m_waitrequest = 1'b0;
      cyc(2);
      check("rst_m_write", m_write, 0);
      check("rst_m_address", m_address, 0);
      check("rst_m_writedata", m_writedata, 0);
      check("rst_m_byteenable", m_byteenable, 0);
      check("rst_busy", busy, 0);
      check("rst_clamped", clamped, 0);
      check("rst_hex", hex_value, 0);
      reset_n = 1'b1;
      cyc(2);

      // 1: first draw, nothing to erase
      base = wr_total;
      push_square(100, 50, COL);
      enable  = 1'b1;
      x_coord = 100;
      y_coord = 50;
      wait_done("t1");
      check("t1_count", wr_total - base, 16);
      check("t1_first_addr", log_addr[base], 32'h0001_90C8);
      check("t1_clamped", clamped, 0);
`ifdef CURSOR_HEX_EN
      check("t1_hex", hex_value, 16'h6432);
`else
      check("t1_hex", hex_value, 16'h0000);
`endif

      // 2: move right, erase then draw
      base = wr_total;
      push_square(100, 50, BG);
      push_square(200, 50, COL);
      x_coord = 200;
      wait_done("t2");
      check("t2_count", wr_total - base, 32);
      check("t2_erase_addr", log_addr[base], 32'h0001_90C8);
      check("t2_draw_addr", log_addr[base + 16], 32'h0001_9190);

      // 3: off-screen request clamps to (636,476): 476*2048 + 636*2
      base = wr_total;
      push_square(200, 50, BG);
      push_square(636, 476, COL);
      x_coord = 700;
      y_coord = 600;
      wait_done("t3");
      check("t3_count", wr_total - base, 32);
      check("t3_draw_addr", log_addr[base + 16], 32'h000E_E4F8);
      check("t3_clamped", clamped, 1);

      // enable low: coordinate change is ignored
      base    = wr_total;
      enable  = 1'b0;
      x_coord = 10;
      y_coord = 20;
      cyc(20);
      check("dis_writes", wr_total - base, 0);
      check("dis_busy", busy, 0);

      // 4: waitrequest held 3 cycles on the 5th draw write
      base = wr_total;
      push_square(636, 476, BG);
      push_square(10, 20, COL);
      enable = 1'b1;
      wait_writes("t4_pre_stall", base + 20);
      m_waitrequest = 1'b1;
      cyc(3);
      m_waitrequest = 1'b0;
      wait_done("t4");
      check("t4_count", wr_total - base, 32);
      check("t4_clamped", clamped, 0);

      // 5: toggling x never settles; draw starts 5 cycles after the hold
      base = wr_total;
      for (int i = 0; i < 6; i++) begin
         x_coord = (i % 2) ? 31 : 30;
         cyc(2);
      end
      check("t5_no_writes", wr_total - base, 0);
      push_square(10, 20, BG);
      push_square(40, 20, COL);
      x_coord = 40;
      @(posedge clk);
      k = 0;
      while (k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
         if (m_write) break;
      end
      check("t5_latency", k, 5);
      wait_done("t5");
      check("t5_count", wr_total - base, 32);

      // 6: reset mid-draw; next draw has no erase
      base = wr_total;
      push_square(40, 20, BG);
      push_square(300, 200, COL);
      x_coord = 300;
      y_coord = 200;
      wait_writes("t6_mid_draw", base + 22);
      reset_n = 1'b0;
      #1;
      check("t6_rst_m_write", m_write, 0);
      check("t6_rst_busy", busy, 0);
      exp_q.delete();
      x_coord = 50;
      y_coord = 60;
      cyc(2);
      reset_n = 1'b1;
      base = wr_total;
      push_square(50, 60, COL);
      wait_done("t6");
      check("t6_count", wr_total - base, 16);
      check("t6_first_addr", log_addr[base], 32'h0001_E064);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
